z80_bus_responder: RTL and testbench

Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

---
 rtl/z80_resp_pkg.sv | 22 ++
 rtl/z80_bus_responder_if.sv | 23 ++
 rtl/z80_cycle_decode.sv | 24 ++
 rtl/z80_bus_responder.sv | 100 ++++++++++
 tb/tb_z80_bus_responder.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/z80_resp_pkg.sv
// z80_resp_pkg: shared types and constants for the Z80 bus responder.
package z80_resp_pkg;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_DRIVE, S_HOLD, S_DRAIN} state_t;

    typedef enum logic [2:0] {C_NONE, C_MEM_RD, C_MEM_WR, C_IO_RD, C_IO_WR, C_INTA, C_REFRESH} cls_t;

    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

    function automatic logic is_xfer(cls_t c);
        return c inside {C_MEM_RD, C_MEM_WR, C_IO_RD, C_IO_WR};
    endfunction

    function automatic logic is_write(cls_t c);
        return c inside {C_MEM_WR, C_IO_WR};
    endfunction

    function automatic logic is_io(cls_t c);
        return c inside {C_IO_RD, C_IO_WR};
    endfunction

endpackage

// File: rtl/z80_bus_responder_if.sv
// z80_bus_responder_if: CPU-side strobes/data plus backend request/ack bundle.
interface z80_bus_responder_if;
    logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
    logic [15:0] A;
    logic [7:0]  D_in, D_out;
    logic        D_oe, nWAIT;
    logic        req, we, is_io;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [7:0]  rdata, int_vector;
    logic        proto_err;

    modport slave (
        input  nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, A, D_in, ack, rdata, int_vector,
        output D_out, D_oe, nWAIT, req, we, is_io, addr, wdata, proto_err
    );

    modport master (
        output nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, A, D_in, ack, rdata, int_vector,
        input  D_out, D_oe, nWAIT, req, we, is_io, addr, wdata, proto_err
    );
endinterface

// File: rtl/z80_cycle_decode.sv
// z80_cycle_decode: classifies sampled strobes into a bus cycle and flags illegal combinations.
module z80_cycle_decode
    import z80_resp_pkg::*;
(
    input  logic m1,
    input  logic mreq,
    input  logic iorq,
    input  logic rd,
    input  logic wr,
    input  logic rfsh,
    output cls_t cls,
    output logic err
);
    always_comb begin
        err = (!rd && !wr) || (!mreq && !iorq);
        cls = err            ? C_NONE    :
              (!mreq && !rfsh) ? C_REFRESH :
              (!m1 && !iorq)   ? C_INTA    :
              (!mreq && !rd)   ? C_MEM_RD  :
              (!mreq && !wr)   ? C_MEM_WR  :
              (!iorq && !rd)   ? C_IO_RD   :
              (!iorq && !wr)   ? C_IO_WR   : C_NONE;
    end
endmodule

// File: rtl/z80_bus_responder.sv
// z80_bus_responder: turns sampled Z80 bus cycles into single backend requests,
// stalling the CPU with nWAIT and driving read/interrupt data back onto the bus.
module z80_bus_responder
    import z80_resp_pkg::*;
#(
    parameter int         ACK_TIMEOUT    = 255,
    parameter logic [7:0] INT_VECTOR_DEF = 8'hFF
) (
    input logic CLK,
    input logic RESET,
    z80_bus_responder_if.slave bus
);
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state, state_n;
    cls_t        cls;
    logic        s_m1, s_mreq, s_iorq, s_rd, s_wr, s_rfsh;
    logic        err, err_q, perr_q;
    logic [15:0] addr_q;
    logic        we_q, io_q, aborted, inta_f;
    logic [7:0]  wdata_q, dout_q, vec_q, cnt;
    logic        xfer_start, inta_start, released, done, drop;

    z80_cycle_decode u_dec (
        .m1(s_m1), .mreq(s_mreq), .iorq(s_iorq), .rd(s_rd), .wr(s_wr), .rfsh(s_rfsh),
        .cls(cls), .err(err)
    );

    always_comb begin
        xfer_start = state == S_IDLE && is_xfer(cls);
        inta_start = state == S_IDLE && cls == C_INTA;
        released   = (io_q ? s_iorq : s_mreq) || (we_q ? s_wr : s_rd);
        done       = bus.ack || cnt == TO_LAST;
        drop       = aborted || released;
        state_n    = state;
        case (state)
            S_IDLE:  state_n = xfer_start ? S_REQ : inta_start ? S_DRIVE : S_IDLE;
            S_REQ:   state_n = !done ? S_REQ : drop ? S_DRAIN : we_q ? S_HOLD : S_DRIVE;
            S_DRIVE: state_n = (inta_f ? s_iorq : s_rd) ? S_IDLE : S_DRIVE;
            S_HOLD:  state_n = s_wr ? S_IDLE : S_HOLD;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            {s_m1, s_mreq, s_iorq, s_rd, s_wr, s_rfsh} <= 6'b111111;
            err_q   <= 1'b0;
            perr_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            wdata_q <= '0;
            dout_q  <= '0;
            vec_q   <= INT_VECTOR_DEF;
            cnt     <= '0;
            aborted <= 1'b0;
            inta_f  <= 1'b0;
        end else begin
            {s_m1, s_mreq, s_iorq, s_rd, s_wr, s_rfsh} <= {bus.nM1, bus.nMREQ, bus.nIORQ, bus.nRD, bus.nWR, bus.nRFSH};
            err_q  <= err;
            perr_q <= err && !err_q;
            vec_q  <= bus.int_vector;
            if (xfer_start) begin
                addr_q  <= bus.A;
                we_q    <= is_write(cls);
                io_q    <= is_io(cls);
                wdata_q <= bus.D_in;
                cnt     <= '0;
                aborted <= 1'b0;
                inta_f  <= 1'b0;
            end
            if (inta_start) begin
                dout_q <= vec_q;
                inta_f <= 1'b1;
            end
            if (state == S_REQ) begin
                cnt <= cnt + 8'd1;
                if (released) aborted <= 1'b1;
                // Aborted reads never update the bus data: the CPU is no longer listening.
                if (done && !we_q && !drop) dout_q <= bus.ack ? bus.rdata : TIMEOUT_DATA;
            end
        end
    end

    assign bus.req       = state == S_REQ;
    assign bus.nWAIT     = !(state == S_REQ || xfer_start);
    assign bus.D_oe      = state == S_DRIVE;
    assign bus.D_out     = dout_q;
    assign bus.addr      = addr_q;
    assign bus.we        = we_q;
    assign bus.is_io     = io_q;
    assign bus.wdata     = wdata_q;
    assign bus.proto_err = perr_q;
endmodule

// File: tb/tb_z80_bus_responder.sv
// tb_z80_bus_responder: directed checks of the Z80 bus responder with a 16-cycle ack timeout.
module tb_z80_bus_responder;
    logic CLK, RESET;
    z80_bus_responder_if bus ();

    z80_bus_responder #(.ACK_TIMEOUT(16), .INT_VECTOR_DEF(8'hFF)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int passed = 0, total = 0;
    int reqc, waitc, oec, errc, unstable;
    logic seen_we, seen_io, acked;
    logic [7:0] seen_wdata;
    logic [15:0] exp_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clr();
        reqc = 0; waitc = 0; oec = 0; errc = 0; unstable = 0;
        seen_we = 1'bx; seen_io = 1'bx; seen_wdata = 'x; acked = 1'b0;
    endtask

    // Outputs are sampled on the falling edge, half a cycle after the design updates.
    task automatic tick();
        @(negedge CLK);
        if (bus.req) begin
            reqc++;
            seen_we = bus.we; seen_io = bus.is_io; seen_wdata = bus.wdata;
            if (bus.addr !== exp_addr) unstable++;
        end
        if (!bus.nWAIT) waitc++;
        if (bus.D_oe) oec++;
        if (bus.proto_err) errc++;
    endtask

    task automatic idle_bus();
        bus.nM1 = 1; bus.nMREQ = 1; bus.nIORQ = 1; bus.nRD = 1; bus.nWR = 1; bus.nRFSH = 1;
    endtask

    initial begin
        idle_bus();
        bus.A = '0; bus.D_in = '0; bus.ack = 0; bus.rdata = '0; bus.int_vector = 8'hE7;
        exp_addr = '0;
        clr();
        RESET = 1;
        repeat (3) tick();
        check("rst_req", 32'(bus.req), 0);
        check("rst_nwait", 32'(bus.nWAIT), 1);
        check("rst_doe", 32'(bus.D_oe), 0);
        check("rst_dout", 32'(bus.D_out), 0);
        check("rst_addr", 32'(bus.addr), 0);
        check("rst_perr", 32'(bus.proto_err), 0);
        RESET = 0;
        tick();

        // memory read, ack on third request cycle; A wiggles to prove addr is latched
        clr(); exp_addr = 16'h1234;
        bus.A = 16'h1234; bus.rdata = 8'h5A; bus.nMREQ = 0; bus.nRD = 0;
        for (int i = 0; i < 12 && !bus.D_oe; i++) begin
            tick();
            if (reqc == 1) bus.A = 16'hBEEF;
            bus.ack = (reqc == 3 && !acked);
            if (bus.ack) acked = 1;
        end
        check("mr_req_cycles", reqc, 3);
        check("mr_wait_cycles", waitc, 4);
        check("mr_addr_stable", unstable, 0);
        check("mr_we", 32'(seen_we), 0);
        check("mr_doe", 32'(bus.D_oe), 1);
        check("mr_dout", 32'(bus.D_out), 'h5A);
        tick(); tick();
        check("mr_doe_held", 32'(bus.D_oe), 1);
        idle_bus();
        tick();
        check("mr_doe_lag", 32'(bus.D_oe), 1);
        tick();
        check("mr_doe_drop", 32'(bus.D_oe), 0);

        // io write with immediate ack
        clr(); exp_addr = 16'h00FE;
        bus.A = 16'h00FE; bus.D_in = 8'hC3; bus.nIORQ = 0; bus.nWR = 0;
        repeat (5) begin
            tick();
            bus.ack = (reqc == 1 && !acked);
            if (bus.ack) acked = 1;
        end
        check("iow_req_cycles", reqc, 1);
        check("iow_is_io", 32'(seen_io), 1);
        check("iow_we", 32'(seen_we), 1);
        check("iow_wdata", 32'(seen_wdata), 'hC3);
        check("iow_addr", unstable, 0);
        check("iow_wait_cycles", waitc, 2);
        check("iow_nwait", 32'(bus.nWAIT), 1);
        idle_bus();
        tick(); tick();
        check("iow_no_doe", oec, 0);

        // interrupt acknowledge
        clr();
        bus.nM1 = 0; bus.nIORQ = 0;
        repeat (3) tick();
        check("inta_no_req", reqc, 0);
        check("inta_no_wait", waitc, 0);
        check("inta_doe", 32'(bus.D_oe), 1);
        check("inta_dout", 32'(bus.D_out), 'hE7);
        idle_bus();
        tick();
        check("inta_doe_lag", 32'(bus.D_oe), 1);
        tick();
        check("inta_doe_drop", 32'(bus.D_oe), 0);

        // read timeout
        clr(); exp_addr = 16'h4000;
        bus.A = 16'h4000; bus.nMREQ = 0; bus.nRD = 0;
        repeat (20) tick();
        check("to_req_cycles", reqc, 16);
        check("to_wait_cycles", waitc, 17);
        check("to_doe", 32'(bus.D_oe), 1);
        check("to_dout", 32'(bus.D_out), 'hFF);
        idle_bus();
        tick(); tick();

        // illegal strobe combinations
        clr();
        bus.nMREQ = 0; bus.nRD = 0; bus.nWR = 0;
        repeat (4) tick();
        check("perr_rdwr_pulse", errc, 1);
        check("perr_rdwr_noreq", reqc, 0);
        check("perr_rdwr_nowait", waitc, 0);
        idle_bus();
        tick(); tick();
        clr();
        bus.nMREQ = 0; bus.nIORQ = 0; bus.nRD = 0;
        repeat (4) tick();
        check("perr_mrio_pulse", errc, 1);
        check("perr_mrio_noreq", reqc, 0);
        idle_bus();
        tick(); tick();

        // refresh and stray ack
        clr();
        bus.nMREQ = 0; bus.nRFSH = 0;
        repeat (4) tick();
        idle_bus();
        bus.ack = 1;
        tick();
        bus.ack = 0;
        tick();
        check("rfsh_noreq", reqc, 0);
        check("rfsh_nowait", waitc, 0);
        check("rfsh_nodoe", oec, 0);

        // reset in the middle of an io read request
        clr(); exp_addr = 16'h5555;
        bus.A = 16'h5555; bus.D_in = 8'h3C; bus.nIORQ = 0; bus.nRD = 0;
        repeat (3) tick();
        check("mid_req", 32'(bus.req), 1);
        check("mid_is_io", 32'(bus.is_io), 1);
        RESET = 1;
        tick();
        check("mid_rst_req", 32'(bus.req), 0);
        check("mid_rst_nwait", 32'(bus.nWAIT), 1);
        check("mid_rst_addr", 32'(bus.addr), 0);
        check("mid_rst_is_io", 32'(bus.is_io), 0);
        check("mid_rst_wdata", 32'(bus.wdata), 0);
        check("mid_rst_dout", 32'(bus.D_out), 0);
        check("mid_rst_doe", 32'(bus.D_oe), 0);
        idle_bus();
        RESET = 0;
        tick(); tick();

        // strobe abort before ack
        clr(); exp_addr = 16'h7777;
        bus.A = 16'h7777; bus.rdata = 8'hAA; bus.nMREQ = 0; bus.nRD = 0;
        repeat (3) tick();
        idle_bus();
        repeat (3) tick();
        check("abt_req_held", 32'(bus.req), 1);
        bus.ack = 1;
        tick();
        bus.ack = 0;
        repeat (3) tick();
        check("abt_req_cycles", reqc, 5);
        check("abt_req_drop", 32'(bus.req), 0);
        check("abt_no_doe", oec, 0);
        check("abt_dout_kept", 32'(bus.D_out), 0);
        check("abt_nwait", 32'(bus.nWAIT), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
